// File: rtl/reorder_buffer_if.sv
// Issue / CDB / query / commit bundle of the reorder buffer.
// slave = the ROB itself, master = the surrounding core (or a bench).
interface reorder_buffer_if #(
    parameter int ROB_BIT = 3,
    parameter int DAT_W   = 32,
    parameter int REG_BIT = 5
);
    logic                is_alloc_i;
    logic [REG_BIT-1:0]  is_rd_i;
    logic                is_br_i;
    logic [ROB_BIT-1:0]  rob_tag_o;
    logic                rob_full_o;

    logic                cdb_en_i;
    logic [ROB_BIT-1:0]  cdb_tag_i;
    logic [DAT_W-1:0]    cdb_v_i;
    logic                cdb_mispred_i;
    logic [DAT_W-1:0]    cdb_pc_i;

    logic [ROB_BIT-1:0]  qj_tag_i;
    logic [ROB_BIT-1:0]  qk_tag_i;
    logic                qj_rdy_o;
    logic                qk_rdy_o;
    logic [DAT_W-1:0]    qj_v_o;
    logic [DAT_W-1:0]    qk_v_o;

    logic                rf_en_o;
    logic [REG_BIT-1:0]  rf_rd_o;
    logic [ROB_BIT-1:0]  rf_q_o;
    logic [DAT_W-1:0]    rf_v_o;
    logic                flush_o;
    logic [DAT_W-1:0]    flush_pc_o;

    modport slave (
        input  is_alloc_i, is_rd_i, is_br_i,
        input  cdb_en_i, cdb_tag_i, cdb_v_i, cdb_mispred_i, cdb_pc_i,
        input  qj_tag_i, qk_tag_i,
        output rob_tag_o, rob_full_o,
        output qj_rdy_o, qk_rdy_o, qj_v_o, qk_v_o,
        output rf_en_o, rf_rd_o, rf_q_o, rf_v_o, flush_o, flush_pc_o
    );

    modport master (
        output is_alloc_i, is_rd_i, is_br_i,
        output cdb_en_i, cdb_tag_i, cdb_v_i, cdb_mispred_i, cdb_pc_i,
        output qj_tag_i, qk_tag_i,
        input  rob_tag_o, rob_full_o,
        input  qj_rdy_o, qk_rdy_o, qj_v_o, qk_v_o,
        input  rf_en_o, rf_rd_o, rf_q_o, rf_v_o, flush_o, flush_pc_o
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tags 1..2^ROB_BIT-1 (tag 0 = no producer), in-order commit, flush on mispredict.
// Optional ROB_CDB_BYPASS_EN: operand queries see a same-cycle CDB result combinationally.
module reorder_buffer #(
    parameter int ROB_BIT = 3,
    parameter int DAT_W   = 32,
    parameter int REG_BIT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    reorder_buffer_if.slave   bus
);
    localparam int N     = (1 << ROB_BIT) - 1;
    localparam int DEPTH = 1 << ROB_BIT;

    typedef logic [ROB_BIT-1:0] tag_t;

    typedef struct packed {
        logic               valid;
        logic               ready;
        logic               br;
        logic               mispred;
        logic [REG_BIT-1:0] rd;
        logic [DAT_W-1:0]   value;
        logic [DAT_W-1:0]   pc;
    } rob_ent_t;

    typedef struct packed {
        logic             rdy;
        logic [DAT_W-1:0] v;
    } qres_t;

    function automatic tag_t ptr_inc(input tag_t p);
        return (p == tag_t'(N)) ? tag_t'(1) : p + tag_t'(1);
    endfunction

    tag_t              r_head;
    tag_t              r_tail;
    tag_t              r_count;

    logic              r_rf_en;
    logic [REG_BIT-1:0] r_rf_rd;
    tag_t              r_rf_q;
    logic [DAT_W-1:0]  r_rf_v;
    logic              r_flush;
    logic [DAT_W-1:0]  r_flush_pc;

    rob_ent_t          w_ent [DEPTH];
    rob_ent_t          w_head_ent;
    logic              w_full;
    logic              w_alloc;
    logic              w_commit;
    logic              w_flush;
    qres_t             w_qj;
    qres_t             w_qk;

    // Fullness is judged on pre-edge state, so a same-edge commit never frees a slot for alloc.
    assign w_full     = (r_count == tag_t'(N));
    assign w_head_ent = w_ent[r_head];
    assign w_alloc    = en && bus.is_alloc_i && !w_full;
    assign w_commit   = en && w_head_ent.valid && w_head_ent.ready;
    assign w_flush    = w_commit && w_head_ent.mispred;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        if (i == 0) begin : g_null
            // Slot 0 is the "no producer" tag and never holds an entry.
            assign w_ent[i] = '0;
        end else begin : g_live
            rob_ent_t r_e;
            logic     w_hit;

            assign w_hit = en && bus.cdb_en_i && (bus.cdb_tag_i == tag_t'(i))
                           && r_e.valid && !r_e.ready;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_e <= '0;
                end else if (w_flush) begin
                    r_e <= '0;
                end else begin
                    if (w_commit && (r_head == tag_t'(i)))
                        r_e <= '0;
                    if (w_alloc && (r_tail == tag_t'(i))) begin
                        r_e.valid   <= 1'b1;
                        r_e.ready   <= 1'b0;
                        r_e.br      <= bus.is_br_i;
                        r_e.mispred <= 1'b0;
                        r_e.rd      <= bus.is_rd_i;
                        r_e.value   <= '0;
                        r_e.pc      <= '0;
                    end
                    if (w_hit) begin
                        r_e.ready   <= 1'b1;
                        r_e.value   <= bus.cdb_v_i;
                        r_e.mispred <= bus.cdb_mispred_i && r_e.br;
                        r_e.pc      <= bus.cdb_pc_i;
                    end
                end
            end

            assign w_ent[i] = r_e;
        end
    end

    always_comb begin
        w_qj = '0;
        w_qk = '0;
        if (w_ent[bus.qj_tag_i].valid && w_ent[bus.qj_tag_i].ready)
            w_qj = '{rdy: 1'b1, v: w_ent[bus.qj_tag_i].value};
        if (w_ent[bus.qk_tag_i].valid && w_ent[bus.qk_tag_i].ready)
            w_qk = '{rdy: 1'b1, v: w_ent[bus.qk_tag_i].value};
`ifdef ROB_CDB_BYPASS_EN
        if (w_ent[bus.qj_tag_i].valid && !w_ent[bus.qj_tag_i].ready
            && bus.cdb_en_i && (bus.cdb_tag_i == bus.qj_tag_i))
            w_qj = '{rdy: 1'b1, v: bus.cdb_v_i};
        if (w_ent[bus.qk_tag_i].valid && !w_ent[bus.qk_tag_i].ready
            && bus.cdb_en_i && (bus.cdb_tag_i == bus.qk_tag_i))
            w_qk = '{rdy: 1'b1, v: bus.cdb_v_i};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= tag_t'(1);
            r_tail     <= tag_t'(1);
            r_count    <= '0;
            r_rf_en    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_q     <= '0;
            r_rf_v     <= '0;
            r_flush    <= 1'b0;
            r_flush_pc <= '0;
        end else if (en) begin
            r_rf_en    <= w_commit && (w_head_ent.rd != '0);
            r_rf_rd    <= w_commit ? w_head_ent.rd : '0;
            r_rf_q     <= w_commit ? r_head : '0;
            r_rf_v     <= w_commit ? w_head_ent.value : '0;
            r_flush    <= w_flush;
            r_flush_pc <= w_flush ? w_head_ent.pc : '0;
            if (w_flush) begin
                r_head  <= tag_t'(1);
                r_tail  <= tag_t'(1);
                r_count <= '0;
            end else begin
                if (w_commit)
                    r_head <= ptr_inc(r_head);
                if (w_alloc)
                    r_tail <= ptr_inc(r_tail);
                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + tag_t'(1);
                    2'b01:   r_count <= r_count - tag_t'(1);
                    default: r_count <= r_count;
                endcase
            end
        end else begin
            // Frozen: pulses drop, payload outputs keep their last value.
            r_rf_en <= 1'b0;
            r_flush <= 1'b0;
        end
    end

    assign bus.rob_tag_o  = r_tail;
    assign bus.rob_full_o = w_full;
    assign bus.qj_rdy_o   = w_qj.rdy;
    assign bus.qj_v_o     = w_qj.v;
    assign bus.qk_rdy_o   = w_qk.rdy;
    assign bus.qk_v_o     = w_qk.v;
    assign bus.rf_en_o    = r_rf_en;
    assign bus.rf_rd_o    = r_rf_rd;
    assign bus.rf_q_o     = r_rf_q;
    assign bus.rf_v_o     = r_rf_v;
    assign bus.flush_o    = r_flush;
    assign bus.flush_pc_o = r_flush_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based program-order model, commit scoreboard checked by a monitor.
module tb_reorder_buffer;
    localparam int ROB_BIT = 3;
    localparam int DAT_W   = 32;
    localparam int REG_BIT = 5;
    localparam int N       = 7;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    reorder_buffer_if #(.ROB_BIT(ROB_BIT), .DAT_W(DAT_W), .REG_BIT(REG_BIT)) bus();

    reorder_buffer #(.ROB_BIT(ROB_BIT), .DAT_W(DAT_W), .REG_BIT(REG_BIT)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus.slave)
    );

    typedef struct {
        int          tag;
        int          rd;
        bit          br;
        bit          rdy;
        bit          mis;
        logic [31:0] val;
        logic [31:0] pc;
    } ment_t;

    typedef struct {
        int          due;
        bit          rfen;
        int          rd;
        int          tag;
        logic [31:0] val;
        bit          fl;
        logic [31:0] pc;
    } exp_t;

    ment_t m_q[$];
    int    m_tail = 1;
    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input bit a, input int rd, input bit br, input bit ce, input int ct,
                         input logic [31:0] cv, input bit mis, input logic [31:0] pc,
                         input int qj, input int qk);
        bus.is_alloc_i    = a;
        bus.is_rd_i       = REG_BIT'(rd);
        bus.is_br_i       = br;
        bus.cdb_en_i      = ce;
        bus.cdb_tag_i     = ROB_BIT'(ct);
        bus.cdb_v_i       = cv;
        bus.cdb_mispred_i = mis;
        bus.cdb_pc_i      = pc;
        bus.qj_tag_i      = ROB_BIT'(qj);
        bus.qk_tag_i      = ROB_BIT'(qk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int find(input int t);
        if (t == 0) return -1;
        foreach (m_q[i]) if (m_q[i].tag == t) return i;
        return -1;
    endfunction

    task automatic query_model(input int t, output bit rdy, output logic [31:0] v);
        int i;
        i = find(t);
        rdy = 0;
        v = 0;
        if (i >= 0) begin
            if (m_q[i].rdy) begin
                rdy = 1;
                v = m_q[i].val;
            end
`ifdef ROB_CDB_BYPASS_EN
            else if (bus.cdb_en_i && int'(bus.cdb_tag_i) == t) begin
                rdy = 1;
                v = bus.cdb_v_i;
            end
`endif
        end
    endtask

    // Called at a negedge with inputs driven: check combinational outputs, advance model, wait one cycle.
    task automatic tick();
        bit          rdy;
        logic [31:0] v;
        bit          commit;
        bit          fl;
        bit          full;
        int          i;
        exp_t        e;
        #1;
        chk("rob_tag", 32'(bus.rob_tag_o), 32'(m_tail));
        chk("rob_full", 32'(bus.rob_full_o), 32'(m_q.size() == N));
        query_model(int'(bus.qj_tag_i), rdy, v);
        chk("qj_rdy", 32'(bus.qj_rdy_o), 32'(rdy));
        chk("qj_v", bus.qj_v_o, v);
        query_model(int'(bus.qk_tag_i), rdy, v);
        chk("qk_rdy", 32'(bus.qk_rdy_o), 32'(rdy));
        chk("qk_v", bus.qk_v_o, v);
        if (en) begin
            full   = (m_q.size() == N);
            commit = (m_q.size() > 0) && m_q[0].rdy;
            fl     = commit && m_q[0].mis;
            if (commit && (m_q[0].rd != 0 || fl)) begin
                e.due  = cyc + 1;
                e.rfen = (m_q[0].rd != 0);
                e.rd   = m_q[0].rd;
                e.tag  = m_q[0].tag;
                e.val  = m_q[0].val;
                e.fl   = fl;
                e.pc   = m_q[0].pc;
                exp_q.push_back(e);
            end
            if (fl) begin
                m_q.delete();
                m_tail = 1;
            end else begin
                if (bus.cdb_en_i) begin
                    i = find(int'(bus.cdb_tag_i));
                    if (i >= 0 && !m_q[i].rdy) begin
                        m_q[i].rdy = 1;
                        m_q[i].val = bus.cdb_v_i;
                        m_q[i].mis = bus.cdb_mispred_i && m_q[i].br;
                        m_q[i].pc  = bus.cdb_pc_i;
                    end
                end
                if (commit) void'(m_q.pop_front());
                if (bus.is_alloc_i && !full) begin
                    m_q.push_back('{tag: m_tail, rd: int'(bus.is_rd_i), br: bus.is_br_i,
                                    rdy: 0, mis: 0, val: 0, pc: 0});
                    m_tail = (m_tail == N) ? 1 : m_tail + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_rob_tag", 32'(bus.rob_tag_o), 32'd1);
        chk("rst_full", 32'(bus.rob_full_o), 32'd0);
        m_q.delete();
        m_tail = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rf_en", 32'(bus.rf_en_o), 32'd0);
        chk("rst_flush", 32'(bus.flush_o), 32'd0);
        chk("rst_rf_v", bus.rf_v_o, 32'd0);
        chk("rst_flush_pc", bus.flush_pc_o, 32'd0);
        rst = 1'b1;
    endtask

    // Drive CDB results for every pending entry until the model is empty (bounded).
    task automatic drain();
        int k;
        for (int c = 0; c < 60 && m_q.size() > 0; c++) begin
            k = -1;
            foreach (m_q[i]) if (k < 0 && !m_q[i].rdy) k = i;
            if (k >= 0) drive(0, 0, 0, 1, m_q[k].tag, $urandom, 0, 0, m_q[0].tag, 0);
            else idle();
            tick();
        end
        chk("drain_empty", 32'(m_q.size()), 32'd0);
    endtask

    // Monitor: every posedge, compare committed pulses against the scoreboard.
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_commit: tag %0d got nothing want commit at cycle %0d", e.tag, e.due);
            end
            if (bus.rf_en_o || bus.flush_o) begin
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: got rf_en=%0b q=%0d flush=%0b want none (cycle %0d)",
                             bus.rf_en_o, bus.rf_q_o, bus.flush_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_en", 32'(bus.rf_en_o), 32'(e.rfen));
                    if (e.rfen) begin
                        chk("rf_rd", 32'(bus.rf_rd_o), 32'(e.rd));
                        chk("rf_q", 32'(bus.rf_q_o), 32'(e.tag));
                        chk("rf_v", bus.rf_v_o, e.val);
                    end
                    chk("flush", 32'(bus.flush_o), 32'(e.fl));
                    if (e.fl) chk("flush_pc", bus.flush_pc_o, e.pc);
                end
            end
        end
    end

    initial begin : stim
        int pend;
        en = 1'b1;
        idle();
        @(negedge clk);
        do_reset();

        // Fill: tags 1..7, then a rejected alloc while full.
        for (int r = 1; r <= N; r++) begin
            drive(1, r, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        chk("full_after7", 32'(bus.rob_full_o), 32'd1);
        drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("tag_after_rejected", 32'(bus.rob_tag_o), 32'd1);

        // Out-of-order results: tag 3 first, then 1 and 2.
        drive(0, 0, 0, 1, 3, 32'h33, 0, 0, 3, 1);
        tick();
        idle();
        tick();
        tick();
        drive(0, 0, 0, 1, 1, 32'h11, 0, 0, 1, 2);
        tick();
        drive(0, 0, 0, 1, 2, 32'h22, 0, 0, 2, 3);
        tick();
        idle();
        for (int c = 0; c < 4; c++) tick();
        drain();

        // Steady fill/drain: tail wraps, tag 0 never issued.
        for (int c = 0; c < 24; c++) begin
            pend = (m_q.size() > 0 && !m_q[0].rdy) ? m_q[0].tag : 0;
            drive(1, 1 + $urandom_range(0, 30), 0, pend != 0, pend, $urandom, 0, 0,
                  $urandom_range(0, 7), $urandom_range(0, 7));
            tick();
            chk("tag_nonzero", 32'(bus.rob_tag_o != 0), 32'd1);
        end
        drain();

        // Reset mid-operation with live entries, then the mispredict scenario from tag 1.
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 3, 32'h3, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 4, 32'h4, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 2, 32'h2c, 1, 32'h100, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 32'h1, 0, 0, 0, 0); tick();
        idle();
        for (int c = 0; c < 4; c++) tick();
        chk("flush_tag_reset", 32'(bus.rob_tag_o), 32'd1);
        chk("flush_empty", 32'(bus.rob_full_o), 32'd0);

        // Query vs same-cycle CDB write, and a tag-0 query.
        for (int r = 1; r <= 5; r++) begin
            drive(1, r, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 5, 32'h55, 0, 0, 5, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        tick();
        chk("q5_ready_next", 32'(bus.qj_rdy_o), 32'd1);
        chk("q0_not_ready", 32'(bus.qk_rdy_o), 32'd0);

        // en low for 3 cycles with a ready head.
        drive(0, 0, 0, 1, 1, 32'hab, 0, 0, 1, 0);
        tick();
        idle();
        en = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        en = 1'b1;
        tick();
        drain();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 7) != 0);
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                pend = m_q[$urandom_range(0, m_q.size() - 1)].tag;
            else
                pend = $urandom_range(0, 7);
            drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) != 0, pend, $urandom, $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 7), $urandom_range(0, 7));
            tick();
        end
        en = 1'b1;
        drain();
        idle();
        for (int c = 0; c < 3; c++) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
